// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter with a small byte FIFO in front
//
// Purpose: accepts bytes through a valid/ready handshake into a circular FIFO
// and serialises them LSB first, line idle high, frames back-to-back.
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_reset_n    synchronous active-low reset
//   i_tx_valid   byte offered on i_tx_byte
//   i_tx_byte    byte to send
//   o_tx_ready   FIFO not full; push happens when i_tx_valid && o_tx_ready
//   o_tx_serial  registered serial line
//   o_tx_busy    high whenever a frame is in progress
//   o_tx_done    one-cycle pulse after each stop bit completes
//   o_fifo_cnt   bytes waiting in the FIFO (excludes the byte being sent)
module uart_tx_fifo #(
  parameter int BIT_CLK_PER = 868,
  parameter int FIFO_AW     = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_tx_valid,
  input  logic [7:0]         i_tx_byte,
  output logic               o_tx_ready,
  output logic               o_tx_serial,
  output logic               o_tx_busy,
  output logic               o_tx_done,
  output logic [FIFO_AW:0]   o_fifo_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [9:0]         BIT_LAST = 10'(BIT_CLK_PER - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    cnt_q;
  logic [7:0]          shift_q, shift_d;
  logic [9:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic                serial_q, serial_d;
  logic                done_q, done_d;
  logic                push, pop, bit_end, have_byte;

  // Ready comes from the registered count, so a full FIFO stays unready on
  // the edge that pops it; the waiting byte goes in one edge later.
  assign o_tx_ready = (cnt_q != DEPTH_C);
  assign push       = i_tx_valid && o_tx_ready;
  assign have_byte  = (cnt_q != '0);
  assign bit_end    = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q + 10'd1;
    idx_d     = idx_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        serial_d  = 1'b1;
        bit_cnt_d = '0;
        idx_d     = '0;
        if (have_byte) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          serial_d = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          serial_d  = shift_q[0];
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d    = '0;
            serial_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            // Bit 0 of the shifter is always the bit currently on the line.
            shift_d  = {1'b0, shift_q[7:1]};
            serial_d = shift_q[1];
            idx_d    = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          done_d    = 1'b1;
          if (have_byte) begin
            // Chain straight into the next start bit: no idle gap.
            pop      = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            serial_d = 1'b0;
            state_d  = S_START;
          end else begin
            serial_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        serial_d  = 1'b1;
        bit_cnt_d = '0;
        idx_d     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_tx_byte;
  end

  assign o_tx_serial = serial_q;
  assign o_tx_busy   = (state_q != S_IDLE);
  assign o_tx_done   = done_q;
  assign o_fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int P    = 16;
  localparam int AW   = 2;
  localparam int LOGN = 8192;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tx_valid = 1'b0;
  logic [7:0]    tx_byte = 8'h00;
  logic          tx_ready, tx_serial, tx_busy, tx_done;
  logic [AW:0]   fifo_cnt;

  uart_tx_fifo #(.BIT_CLK_PER(P), .FIFO_AW(AW)) dut (
    .i_clk       (clk),
    .i_reset_n   (resetn),
    .i_tx_valid  (tx_valid),
    .i_tx_byte   (tx_byte),
    .o_tx_ready  (tx_ready),
    .o_tx_serial (tx_serial),
    .o_tx_busy   (tx_busy),
    .o_tx_done   (tx_done),
    .o_fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Per-edge log: index k holds outputs as they settle after rising edge k.
  int   cyc = 0;
  logic log_ser  [LOGN];
  logic log_busy [LOGN];
  logic log_done [LOGN];
  int   log_cnt  [LOGN];

  always @(posedge clk) begin
    #2;
    if (cyc < LOGN) begin
      log_ser[cyc]  = tx_serial;
      log_busy[cyc] = tx_busy;
      log_done[cyc] = tx_done;
      log_cnt[cyc]  = int'(fifo_cnt);
    end
    cyc = cyc + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int sum_busy(input int a, input int len);
    int s = 0;
    for (int i = a; i < a + len; i++) s += int'(log_busy[i]);
    return s;
  endfunction

  function automatic int sum_done(input int a, input int len);
    int s = 0;
    for (int i = a; i < a + len; i++) s += int'(log_done[i]);
    return s;
  endfunction

  function automatic int sum_ser(input int a, input int len);
    int s = 0;
    for (int i = a; i < a + len; i++) s += int'(log_ser[i]);
    return s;
  endfunction

  // Frame starting at log index s: compare every cycle against the ideal
  // 8N1 waveform of exp, and decode the byte from mid-bit samples.
  task automatic check_frame(input string nm, input int s, input logic [7:0] exp);
    logic [9:0] fr;
    logic [7:0] got;
    int err = 0;
    fr = {1'b1, exp, 1'b0};
    for (int t = 0; t < 10 * P; t++)
      if (log_ser[s + t] !== fr[t / P]) err++;
    for (int b = 0; b < 8; b++) got[b] = log_ser[s + P * (b + 1) + P / 2];
    chk({nm, " waveform errors"}, err, 0);
    chk({nm, " decoded byte"}, int'(got), int'(exp));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge e.
  task automatic push_byte(input logic [7:0] b, output int e);
    int guard = 0;
    tx_valid = 1'b1;
    tx_byte  = b;
    while (!tx_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("push accepted before timeout", int'(tx_ready), 1);
    e = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit i = line level during bit slot i (slot 0 = start)
  } vec_t;

  vec_t vecs [5];
  logic [7:0] burst [6];

  initial begin
    int n, m, r, e0, e5;
    int e [5];

    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};
    burst   = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55, 8'h42};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset serial", int'(tx_serial), 1);
    chk("reset busy", int'(tx_busy), 0);
    chk("reset done", int'(tx_done), 0);
    chk("reset cnt", int'(fifo_cnt), 0);
    chk("reset ready", int'(tx_ready), 1);
    resetn = 1'b1;
    @(negedge clk);

    // Single frames from the table
    for (int v = 0; v < 5; v++) begin
      push_byte(vecs[v].data, n);
      chk("cnt after push into empty fifo", int'(fifo_cnt), 1);
      chk("still idle on push edge", int'(log_ser[n]), 1);
      repeat (175) @(negedge clk);
      for (int b = 0; b < 10; b++)
        chk($sformatf("vec%0d slot%0d", v, b), int'(log_ser[n + 1 + P * b + P / 2]),
            int'(vecs[v].frame[b]));
      check_frame($sformatf("vec%0d", v), n + 1, vecs[v].data);
      chk("busy cycles per frame", sum_busy(n, 176), 10 * P);
      chk("done pulses per frame", sum_done(n, 176), 1);
      chk("done after stop bit", int'(log_done[n + 1 + 10 * P]), 1);
    end

    // Burst with valid held: fill to four, then a sixth byte waits on full
    do_reset();
    for (int k = 0; k < 5; k++) push_byte(burst[k], e[k]);
    e0 = e[0];
    chk("burst pushes on consecutive edges", e[4] - e0, 4);
    chk("fifo full count", int'(fifo_cnt), 4);
    chk("ready low when full", int'(tx_ready), 0);
    push_byte(burst[5], e5);
    chk("held byte accepted edge after pop", e5 - e0, 10 * P + 2);
    chk("cnt on pop edge while full", log_cnt[e5 - 1], 3);
    chk("cnt before pop edge", log_cnt[e5 - 2], 4);
    chk("cnt after held push", int'(fifo_cnt), 4);
    repeat (6 * 10 * P + 20) @(negedge clk);
    for (int f = 0; f < 6; f++)
      check_frame($sformatf("burst frame%0d", f), e0 + 1 + 10 * P * f, burst[f]);
    chk("burst contiguous busy", sum_busy(e0 + 1, 6 * 10 * P + 10), 6 * 10 * P);
    chk("burst done pulses", sum_done(e0 + 1, 6 * 10 * P + 10), 6);
    chk("idle after burst", int'(log_busy[e0 + 1 + 6 * 10 * P]), 0);

    // Reset in the middle of data bit 3 with bytes still queued
    do_reset();
    push_byte(8'hA5, n);
    push_byte(8'h81, m);
    push_byte(8'h3C, m);
    chk("queued before mid-frame reset", int'(fifo_cnt), 2);
    while (cyc < n + 1 + 4 * P + P / 2) @(negedge clk);
    chk("line carries data bit3", int'(tx_serial), 0);
    resetn = 1'b0;
    r = cyc;
    @(negedge clk);
    resetn = 1'b1;
    chk("serial high after reset", int'(tx_serial), 1);
    chk("cnt cleared by reset", int'(fifo_cnt), 0);
    chk("busy cleared by reset", int'(tx_busy), 0);
    chk("ready after reset", int'(tx_ready), 1);
    repeat (200) @(negedge clk);
    chk("no done after abandoned frame", sum_done(r, 200), 0);
    chk("line idle after abandoned frame", sum_ser(r, 200), 200);
    push_byte(8'h55, n);
    repeat (175) @(negedge clk);
    check_frame("post-reset frame", n + 1, 8'h55);
    chk("post-reset done", sum_done(n, 176), 1);

    // Single-cycle push while a frame is in flight
    push_byte(8'h81, n);
    while (cyc < n + 50) @(negedge clk);
    chk("cnt empty during frame", int'(fifo_cnt), 0);
    push_byte(8'h3C, m);
    chk("cnt +1 after single push", int'(fifo_cnt), 1);
    @(negedge clk);
    chk("cnt stays after valid drop", int'(fifo_cnt), 1);
    while (cyc < n + 1 + 20 * P + 10) @(negedge clk);
    check_frame("inflight first", n + 1, 8'h81);
    check_frame("inflight follow-on", n + 1 + 10 * P, 8'h3C);
    chk("inflight contiguous busy", sum_busy(n + 1, 20 * P), 20 * P);
    chk("idle after two frames", int'(log_busy[n + 1 + 20 * P]), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
